// File: rtl/cargo_stop_queue_if.sv
// Request, head-stop and status signals exchanged between the cargo stop queue
// and the elevator control unit.
interface cargo_stop_queue_if #(
   parameter int FLOORS = 4,
   parameter int DEPTH  = 16,
   parameter int TYPE_W = 2
);
   localparam int FW = (FLOORS > 2) ? $clog2(FLOORS) : 1;
   localparam int AW = $clog2(DEPTH + 1);

   logic [FW-1:0]     current_floor;
   logic              req_valid;
   logic              req_ready;
   logic [TYPE_W-1:0] req_type;
   logic [FW-1:0]     req_origin;
   logic [FW-1:0]     req_dest;
   logic              pop;
   logic              head_valid;
   logic [FW-1:0]     head_floor;
   logic              head_is_origin;
   logic [TYPE_W-1:0] head_type;
   logic              sobe;
   logic              chegou;
   logic [AW-1:0]     count;
   logic              busy;
   logic              req_done;
   logic              req_error;

   modport slave (
      input  current_floor, req_valid, req_type, req_origin, req_dest, pop,
      output req_ready, head_valid, head_floor, head_is_origin, head_type,
             sobe, chegou, count, busy, req_done, req_error
   );

   modport master (
      output current_floor, req_valid, req_type, req_origin, req_dest, pop,
      input  req_ready, head_valid, head_floor, head_is_origin, head_type,
             sobe, chegou, count, busy, req_done, req_error
   );
endinterface

// File: rtl/cargo_stop_queue.sv
// Ordered stop list for the cargo elevator: pickups and deliveries ride along
// existing route segments when they lie on the way, otherwise they are appended.
module cargo_stop_queue #(
   parameter int FLOORS = 4,
   parameter int DEPTH  = 16,
   parameter int TYPE_W = 2
) (
   input logic               clock,
   input logic               reset,
   cargo_stop_queue_if.slave bus
);
   localparam int FW = (FLOORS > 2) ? $clog2(FLOORS) : 1;
   localparam int AW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {IDLE, SCAN_O, INS_O, SCAN_D, INS_D, ERR} state_t;

   typedef struct packed {
      logic              isOrigin;
      logic [TYPE_W-1:0] objType;
      logic [FW-1:0]     origin;
      logic [FW-1:0]     dest;
   } entry_t;

   state_t            state;
   entry_t            entries [DEPTH];
   logic [AW-1:0]     count;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     pos;
   logic [TYPE_W-1:0] latType;
   logic [FW-1:0]     latOrigin;
   logic [FW-1:0]     latDest;
   logic              dirUp;
   logic              reqDone;
   logic              reqError;

   logic [FW-1:0]     scanX;
   logic [FW-1:0]     prevStop;
   logic [FW-1:0]     curStop;
   logic [FW-1:0]     headFloor;
   logic [AW-1:0]     hitPos;
   logic              atEnd;
   logic              between;
   logic              onStop;
   logic              scanHit;
   logic              readyInt;
   logic              reqFire;
   logic              badReq;
   entry_t            newEntry;

   function automatic logic [FW-1:0] stopOf(input entry_t e);
      return e.isOrigin ? e.origin : e.dest;
   endfunction

   // Evaluate the segment ending at entry idx; the tail position always hits so
   // insertion never lands beyond the occupied entries.
   always_comb begin
      scanX    = (state == SCAN_O) ? latOrigin : latDest;
      prevStop = bus.current_floor;
      curStop  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == int'(idx)) curStop = stopOf(entries[i]);
         if (i + 1 == int'(idx)) prevStop = stopOf(entries[i]);
      end
      atEnd   = (idx == count);
      between = dirUp ? ((prevStop < scanX) && (scanX < curStop))
                      : ((prevStop > scanX) && (scanX > curStop));
      onStop  = (scanX == curStop) &&
                (dirUp ? (prevStop < curStop) : (prevStop > curStop));
      scanHit = atEnd | between | onStop;
      if (atEnd)        hitPos = count;
      else if (between) hitPos = idx;
      else              hitPos = idx + 1'b1;
   end

   assign readyInt = (state == IDLE) && (int'(count) <= DEPTH - 2) && !bus.pop;
   assign reqFire  = bus.req_valid && readyInt;
   assign badReq   = (bus.req_origin == bus.req_dest) ||
                     (int'(bus.req_origin) >= FLOORS) ||
                     (int'(bus.req_dest) >= FLOORS);
   assign newEntry = '{isOrigin: (state == INS_O), objType: latType,
                       origin: latOrigin, dest: latDest};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         idx       <= '0;
         pos       <= '0;
         latType   <= '0;
         latOrigin <= '0;
         latDest   <= '0;
         dirUp     <= 1'b0;
         reqDone   <= 1'b0;
         reqError  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         reqDone  <= 1'b0;
         reqError <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.pop && (count != '0)) begin
                  for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i + 1];
                  entries[DEPTH-1] <= '0;
                  count <= count - 1'b1;
               end else if (reqFire) begin
                  latType   <= bus.req_type;
                  latOrigin <= bus.req_origin;
                  latDest   <= bus.req_dest;
                  dirUp     <= bus.req_dest > bus.req_origin;
                  idx       <= '0;
                  state     <= badReq ? ERR : SCAN_O;
               end
            end
            SCAN_O, SCAN_D: begin
               if (scanHit) begin
                  pos   <= hitPos;
                  state <= (state == SCAN_O) ? INS_O : INS_D;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            INS_O, INS_D: begin
               // Open a slot at pos by moving the tail up one place.
               for (int i = 1; i < DEPTH; i++)
                  if ((i > int'(pos)) && (i <= int'(count))) entries[i] <= entries[i - 1];
               for (int i = 0; i < DEPTH; i++)
                  if (i == int'(pos)) entries[i] <= newEntry;
               count <= count + 1'b1;
               if (state == INS_O) begin
                  idx   <= pos + 1'b1;
                  state <= SCAN_D;
               end else begin
                  reqDone <= 1'b1;
                  state   <= IDLE;
               end
            end
            ERR: begin
               reqError <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign headFloor          = (count != '0) ? stopOf(entries[0]) : '0;
   assign bus.req_ready      = readyInt;
   assign bus.head_valid     = (count != '0);
   assign bus.head_floor     = headFloor;
   assign bus.head_is_origin = (count != '0) && entries[0].isOrigin;
   assign bus.head_type      = (count != '0) ? entries[0].objType : '0;
   assign bus.sobe           = (count != '0) && (headFloor > bus.current_floor);
   assign bus.chegou         = (count != '0) && (headFloor == bus.current_floor);
   assign bus.count          = count;
   assign bus.busy           = (state != IDLE);
   assign bus.req_done       = reqDone;
   assign bus.req_error      = reqError;
endmodule

// File: tb/tb_cargo_stop_queue.sv
// Randomised scoreboard bench for cargo_stop_queue against a list-based route model.
module tb_cargo_stop_queue;
   localparam int FLOORS = 6;
   localparam int DEPTH  = 6;
   localparam int TYPE_W = 2;
   localparam int FW     = 3;

   typedef struct {
      bit isO;
      int typ;
      int org;
      int dst;
   } entry_t;

   typedef struct {
      bit isErr;
      int latency;
      int cnt;
      int acceptCycle;
   } expect_t;

   logic    clock = 1'b0;
   logic    reset = 1'b0;
   entry_t  model[$];
   expect_t sb[$];
   int      cycle  = 0;
   int      checks = 0;
   int      errors = 0;
   int      cf     = 0;

   cargo_stop_queue_if #(.FLOORS(FLOORS), .DEPTH(DEPTH), .TYPE_W(TYPE_W)) bus ();

   cargo_stop_queue #(.FLOORS(FLOORS), .DEPTH(DEPTH), .TYPE_W(TYPE_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int stopOf(input entry_t e);
      return e.isO ? e.org : e.dst;
   endfunction

   // Where floor x joins the route: inside a same-direction segment, right after
   // an equal stop reached in that direction, or at the tail.
   task automatic findPos(input int x, input bit up, input int start, output int pos, output int k);
      int n = model.size();
      pos = n;
      k   = n - start;
      for (int i = start; i < n; i++) begin
         int p = (i == 0) ? cf : stopOf(model[i-1]);
         int s = stopOf(model[i]);
         if (up ? (p < x && x < s) : (p > x && x > s)) begin
            pos = i; k = i - start; return;
         end
         if (x == s && (up ? p < s : p > s)) begin
            pos = i + 1; k = i - start; return;
         end
      end
   endtask

   always @(negedge clock) begin : monitor
      expect_t e;
      if (reset && (bus.req_done || bus.req_error)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpectedPulse", {30'd0, bus.req_done, bus.req_error}, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("pulseKind", {31'd0, bus.req_error}, {31'd0, e.isErr});
            checkOutput("pulseLatency", cycle - e.acceptCycle, e.latency);
            checkOutput("countAtPulse", {29'd0, bus.count}, e.cnt);
         end
      end
   end

   task automatic issueRequest(input int typ, input int o, input int d);
      expect_t e;
      int n = 0;
      int pO, kO, pD, kD;
      @(negedge clock);
      while (!bus.req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) begin
         checkOutput("readyTimeout", {31'd0, bus.req_ready}, 32'd1);
         return;
      end
      bus.req_valid  = 1'b1;
      bus.req_type   = typ[TYPE_W-1:0];
      bus.req_origin = o[FW-1:0];
      bus.req_dest   = d[FW-1:0];
      e.acceptCycle  = cycle + 1;
      if (o == d || o >= FLOORS || d >= FLOORS) begin
         e.isErr   = 1'b1;
         e.latency = 1;
      end else begin
         findPos(o, d > o, 0, pO, kO);
         model.insert(pO, '{1'b1, typ, o, d});
         findPos(d, d > o, pO + 1, pD, kD);
         model.insert(pD, '{1'b0, typ, o, d});
         e.isErr   = 1'b0;
         e.latency = kO + kD + 4;
      end
      e.cnt = model.size();
      sb.push_back(e);
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((sb.size() != 0 || bus.busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0 || bus.busy) begin
         checkOutput("completionTimeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   task automatic applyStimulus(input int typ, input int o, input int d);
      issueRequest(typ, o, d);
      waitIdle();
   endtask

   task automatic doPop();
      @(negedge clock);
      bus.pop = 1'b1;
      @(posedge clock);
      #1 bus.pop = 1'b0;
      if (model.size() > 0) void'(model.pop_front());
   endtask

   task automatic setFloor(input int f);
      @(negedge clock);
      cf = f;
      bus.current_floor = f[FW-1:0];
   endtask

   task automatic checkHead(input string name);
      int ev, ef, eo, et, es, ec, n;
      logic [11:0] exp;
      @(negedge clock);
      n  = model.size();
      ev = (n > 0);
      ef = ev ? stopOf(model[0]) : 0;
      eo = ev ? int'(model[0].isO) : 0;
      et = ev ? model[0].typ : 0;
      es = (ev && ef > cf);
      ec = (ev && ef == cf);
      exp = {ev[0], eo[0], et[1:0], ef[2:0], es[0], ec[0], n[2:0]};
      checkOutput(name, {20'd0, bus.head_valid, bus.head_is_origin, bus.head_type,
                         bus.head_floor, bus.sobe, bus.chegou, bus.count}, {20'd0, exp});
   endtask

   task automatic drain(input string name);
      while (model.size() > 0) begin
         checkHead(name);
         doPop();
      end
      checkHead(name);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      bus.current_floor = '0;
      bus.req_valid     = 1'b0;
      bus.req_type      = '0;
      bus.req_origin    = '0;
      bus.req_dest      = '0;
      bus.pop           = 1'b0;
      repeat (3) @(negedge clock);
      checkHead("resetHead");
      checkOutput("resetStatus", {29'd0, bus.busy, bus.req_done, bus.req_error}, 32'd0);
      reset = 1'b1;

      setFloor(0);
      applyStimulus(1, 1, 3);
      checkHead("firstRequestHead");
      applyStimulus(2, 2, 3);
      drain("caronaDrain");

      applyStimulus(0, 1, 3);
      applyStimulus(3, 2, 0);
      drain("downAppendDrain");

      applyStimulus(1, 1, 3);
      applyStimulus(1, 2, 2);
      applyStimulus(1, 1, 7);
      applyStimulus(2, 6, 1);
      checkHead("afterErrors");
      drain("errorDrain");

      applyStimulus(0, 1, 2);
      applyStimulus(1, 3, 4);
      applyStimulus(2, 5, 0);
      @(negedge clock);
      checkOutput("fullReady", {31'd0, bus.req_ready}, {31'd0, model.size() <= DEPTH - 2});
      doPop();
      checkHead("fullPop1");
      checkOutput("fullReadyPop1", {31'd0, bus.req_ready}, {31'd0, model.size() <= DEPTH - 2});
      doPop();
      checkHead("fullPop2");
      checkOutput("fullReadyPop2", {31'd0, bus.req_ready}, {31'd0, model.size() <= DEPTH - 2});

      @(negedge clock);
      bus.pop        = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_type   = 2'd1;
      bus.req_origin = 3'd2;
      bus.req_dest   = 3'd4;
      #1 checkOutput("readyWithPop", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clock);
      #1 bus.pop = 1'b0;
      bus.req_valid = 1'b0;
      void'(model.pop_front());
      checkHead("popWinsHead");
      checkOutput("popWinsBusy", {31'd0, bus.busy}, 32'd0);
      drain("popWinsDrain");

      setFloor(0);
      issueRequest(1, 2, 4);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1 checkOutput("midResetCount", {29'd0, bus.count}, 32'd0);
      checkOutput("midResetHead", {31'd0, bus.head_valid}, 32'd0);
      checkOutput("midResetBusy", {31'd0, bus.busy}, 32'd0);
      model.delete();
      sb.delete();
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(1, 2, 4);
      drain("afterResetDrain");

      for (int it = 0; it < 200; it++) begin
         if (model.size() > 0 && ($urandom_range(0, 2) == 0 || model.size() > DEPTH - 2)) begin
            doPop();
         end else begin
            if ($urandom_range(0, 3) == 0) setFloor($urandom_range(0, FLOORS - 1));
            applyStimulus($urandom_range(0, 3), $urandom_range(0, FLOORS),
                          $urandom_range(0, FLOORS));
         end
         checkHead("randomHead");
      end
      drain("randomDrain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cargo_stop_queue.md
# cargo_stop_queue

Parametrised stop-queue engine for the cargo elevator datapath: it accepts transport requests (object type, origin floor, destination floor) and keeps an ordered list of stops. Each request's origin and destination are inserted into the existing route when they lie on the way ("carona"); otherwise they are appended. The block presents the head stop together with direction and arrival flags to the control unit, and generalises the fixed 4-floor/16-entry queue to any floor count and depth.

## Interface
- FLOORS, 4, number of floors; floor width FW = clog2(FLOORS), minimum 1
- DEPTH, 16, queue entries; must be ≥ 2; index/count width AW = clog2(DEPTH+1)
- TYPE_W, 2, object-type width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears all state
- current_floor  in  FW  floor currently reported by the floor interpreter
- req_valid  in  1  request present
- req_ready  out  1  request accepted on clock edge when req_valid & req_ready
- req_type  in  TYPE_W  object type
- req_origin  in  FW  pickup floor
- req_dest  in  FW  delivery floor
- pop  in  1  head stop served; remove entry 0
- head_valid  out  1  queue not empty
- head_floor  out  FW  stop floor of entry 0
- head_is_origin  out  1  entry 0 is a pickup
- head_type  out  TYPE_W  type of entry 0
- sobe  out  1  head_valid & head_floor > current_floor
- chegou  out  1  head_valid & head_floor == current_floor
- count  out  AW  occupied entries
- busy  out  1  insertion in progress (state ≠ IDLE)
- req_done  out  1  one-cycle pulse when a request is fully inserted
- req_error  out  1  one-cycle pulse when an accepted request is rejected

## Operation
- Entry = {is_origin, type, origin, dest}; stop(i) = is_origin ? origin : dest. Entry 0 is the head.
- prev(i) = current_floor for i = 0, else stop(i-1).
- User direction: up if dest > origin, down if dest < origin.
- Segment i matches direction d when (d = up and prev(i) < stop(i)) or (d = down and prev(i) > stop(i)).
- FSM states: IDLE, SCAN_O, INS_O, SCAN_D, INS_D, ERR.
- IDLE: req_ready = (count ≤ DEPTH-2) & ~pop. On accept, latch the request.
  - If origin == dest, or either floor ≥ FLOORS → ERR.
  - Otherwise → SCAN_O with idx = 0.
- SCAN_O examines one idx per cycle, with x = origin:
  - If x lies strictly between prev(idx) and stop(idx) in the user direction → pos = idx.
  - Else if x == stop(idx) and segment idx matches the user direction → pos = idx+1.
  - Else if idx == count → pos = count (append).
  - Otherwise idx++ and stay.
  - On any hit → INS_O.
- INS_O: shift entries pos..count-1 up one place, write an origin entry at pos, count++ → SCAN_D with idx = pos+1.
- SCAN_D / INS_D: same rules with x = dest, starting at pos+1. The insertion writes is_origin = 0. After INS_D, pulse req_done and return to IDLE.
- ERR: pulse req_error for one cycle, leave the queue unchanged → IDLE.
- pop is honoured only in IDLE with count > 0: shift every entry down one place, count--. pop on an empty queue is ignored.
- Simultaneous pop and req_valid in IDLE: pop wins, req_ready is 0 that cycle.
- pop outside IDLE is ignored; the control unit must hold pop until busy = 0.
- Unused entries read as zero. head_* outputs are 0 when the queue is empty.

## Timing
- Reset (asynchronous, low) sets all outputs to 0: count = 0, head_* = 0, busy = 0, pulses = 0, state = IDLE. Asserting reset mid-insertion discards the partial request.
- Latency from accept edge to req_done = (kO+1) + 1 + (kD+1) + 1 cycles, where kO and kD are the number of entries scanned without a hit.
- Error path: req_error is asserted the cycle after the accept edge.
- head_*, sobe, and chegou are combinational from entry 0 and current_floor. They update the cycle after pop or insertion.
- Full condition: req_ready stays low while count > DEPTH-2, so both entries always fit.

## Test plan
- FLOORS=4, current_floor=0, empty queue; request O=1 D=3 → queue [O1, D3]; req_done 4 cycles after accept; head_floor=1, sobe=1.
- Then request O=2 D=3 → [O1, O2, D3, D3] (origin inserted at index 1, destination after the existing D3); req_done 5 cycles after accept.
- Queue [O1, D3], current_floor=0, request O=2 D=0 (down) → appended as [O1, D3, O2, D0].
- Request O=2 D=2, or D=5 with FLOORS=4 → req_error pulse one cycle after accept; count is unchanged.
- DEPTH=4 with count=3 → req_ready=0; after pop, count=2, head shifts, req_ready=1. pop and req_valid together → only pop takes effect.
- Drive reset low during SCAN_D → count=0, head_valid=0, busy=0 immediately; a request after release inserts normally.
